// File: rtl/vec_lane_exec_unit.sv
// Multi-beat vector integer execution unit. It processes one LANE_W slice per cycle and
// leaves tail elements undisturbed. NSUB 32-bit sub-lane ALUs are shared by every beat.

module vec_lane_alu #(
  parameter int VLW = 5
) (
  input  logic [2:0]     op,
  input  logic [1:0]     sew,
  input  logic [VLW-1:0] vl,
  input  logic [VLW-1:0] ebase,  // vector byte index of this sub-lane's byte 0
  input  logic [31:0]    a,
  input  logic [31:0]    b,
  input  logic [31:0]    c,
  output logic [31:0]    y
);
  function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] x,
                                      input logic [31:0] z);
    logic [31:0] r;
    case (f)
      3'b000:  r = x + z;
      3'b001:  r = x - z;
      3'b010:  r = z - x;
      3'b011:  r = x & z;
      3'b100:  r = x | z;
      3'b101:  r = x ^ z;
      3'b110:  r = (x < z) ? x : z;
      default: r = (x < z) ? z : x;
    endcase
    return r;
  endfunction

  logic [31:0] t;

  // Operands are zero-extended per element, so wrap and unsigned compare fall out of truncation.
  always_comb begin
    y = c;
    t = '0;
    case (sew)
      2'b00: for (int i = 0; i < 4; i++) begin
        t = alu(op, {24'b0, a[8*i +: 8]}, {24'b0, b[8*i +: 8]});
        if ((ebase + VLW'(i)) < vl) y[8*i +: 8] = t[7:0];
      end
      2'b01: for (int h = 0; h < 2; h++) begin
        t = alu(op, {16'b0, a[16*h +: 16]}, {16'b0, b[16*h +: 16]});
        if (((ebase >> 1) + VLW'(h)) < vl) y[16*h +: 16] = t[15:0];
      end
      2'b10: begin
        t = alu(op, a, b);
        if ((ebase >> 2) < vl) y = t;
      end
      default: y = c;
    endcase
  end
endmodule

module vec_lane_exec_unit #(
  parameter  int VLEN   = 128,
  parameter  int LANE_W = 32,
  localparam int NBEATS = VLEN / LANE_W,
  localparam int VLW    = $clog2(VLEN / 8) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [1:0]      sew,
  input  logic [VLW-1:0]  vl,
  input  logic [VLEN-1:0] data_1,
  input  logic [VLEN-1:0] data_2,
  input  logic [VLEN-1:0] data_3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] result,
  output logic            busy
);
  localparam int NSUB = LANE_W / 32;
  localparam int BW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [1:0]      sew;
    logic [VLW-1:0]  vl;
    logic [VLEN-1:0] d1;
    logic [VLEN-1:0] d2;
    logic [VLEN-1:0] d3;
  } req_t;

  state_t            state, state_nx;
  req_t              req_q;
  logic [BW-1:0]     beat;
  logic [VLEN-1:0]   res_q;
  logic [LANE_W-1:0] a_s, b_s, c_s, y_s;
  logic              accept;

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = EXEC;
      EXEC:    if (beat == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      beat  <= '0;
      res_q <= '0;
    end else if (accept) begin
      req_q <= {op, sew, vl, data_1, data_2, data_3};
      beat  <= '0;
    end else if (state == EXEC) begin
      res_q[beat*LANE_W +: LANE_W] <= y_s;
      beat <= (beat == LAST) ? '0 : beat + 1'b1;
    end
  end

  assign a_s = req_q.d1[beat*LANE_W +: LANE_W];
  assign b_s = req_q.d2[beat*LANE_W +: LANE_W];
  assign c_s = req_q.d3[beat*LANE_W +: LANE_W];

  for (genvar j = 0; j < NSUB; j++) begin : g_sub
    logic [VLW-1:0] ebase;
    assign ebase = VLW'(beat) * VLW'(LANE_W / 8) + VLW'(j * 4);

    vec_lane_alu #(.VLW(VLW)) u_alu (
      .op    (req_q.op),
      .sew   (req_q.sew),
      .vl    (req_q.vl),
      .ebase (ebase),
      .a     (a_s[32*j +: 32]),
      .b     (b_s[32*j +: 32]),
      .c     (c_s[32*j +: 32]),
      .y     (y_s[32*j +: 32])
    );
  end
endmodule

// File: tb/tb_vec_lane_exec_unit.sv
// Directed bench for vec_lane_exec_unit (128/32), plus a VLEN=256 sweep over three LANE_W values
// against an element-wise reference model.

module tb_vec_lane_exec_unit;
  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready, in_ready, out_valid, busy;
  logic [2:0]   op;
  logic [1:0]   sew;
  logic [4:0]   vl;
  logic [127:0] d1, d2, d3, result;

  logic         in_valid_s, out_ready_s;
  logic [2:0]   op_s;
  logic [1:0]   sew_s;
  logic [5:0]   vl_s;
  logic [255:0] d1s, d2s, d3s;
  logic [2:0]   ir_s, ov_s, bz_s;
  logic [255:0] res_s [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_lane_exec_unit u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sew(sew),
    .vl(vl), .data_1(d1), .data_2(d2), .data_3(d3), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    vec_lane_exec_unit #(.VLEN(256), .LANE_W(32 << g)) u (
      .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(ir_s[g]), .op(op_s),
      .sew(sew_s), .vl(vl_s), .data_1(d1s), .data_2(d2s), .data_3(d3s),
      .out_valid(ov_s[g]), .out_ready(out_ready_s), .result(res_s[g]), .busy(bz_s[g])
    );
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [4:0] v,
                       input logic [127:0] a, input logic [127:0] b, input logic [127:0] c);
    op = o; sew = s; vl = v; d1 = a; d2 = b; d3 = c; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [1:0] s,
                     input logic [4:0] v, input logic [127:0] a, input logic [127:0] b,
                     input logic [127:0] c, input logic [127:0] exp);
    issue(o, s, v, a, b, c);
    wait_out(tag);
    chk(tag, result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  function automatic logic [255:0] model(input logic [2:0] o, input logic [1:0] s,
                                         input logic [5:0] v, input logic [255:0] a,
                                         input logic [255:0] b, input logic [255:0] c);
    logic [255:0] r;
    int ew, ne, lim;
    longint unsigned m, x, z, e;
    r = c;
    if (s == 2'b11) return r;
    ew  = 8 << s;
    ne  = 256 / ew;
    lim = (int'(v) > ne) ? ne : int'(v);
    m   = (64'd1 << ew) - 64'd1;
    for (int i = 0; i < lim; i++) begin
      x = 64'(a >> (i * ew)) & m;
      z = 64'(b >> (i * ew)) & m;
      case (o)
        3'd0:    e = x + z;
        3'd1:    e = x - z;
        3'd2:    e = z - x;
        3'd3:    e = x & z;
        3'd4:    e = x | z;
        3'd5:    e = x ^ z;
        3'd6:    e = (x < z) ? x : z;
        default: e = (x > z) ? x : z;
      endcase
      e = e & m;
      r = (r & ~(256'(m) << (i * ew))) | (256'(e) << (i * ew));
    end
    return r;
  endfunction

  initial begin
    logic [255:0] exp_s;
    int lat [3];
    int n;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; sew = '0; vl = '0;
    d1 = '0; d2 = '0; d3 = '0;
    in_valid_s = 1'b0; out_ready_s = 1'b0; op_s = '0; sew_s = '0; vl_s = '0;
    d1s = '0; d2s = '0; d3s = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_result", result, 128'h0);
    reset = 1'b0;

    run("add_wrap", 3'd0, 2'd0, 5'd16, {16{8'hFF}}, {16{8'h01}}, {16{8'h33}}, 128'h0);
    run("xor_tail", 3'd5, 2'd0, 5'd5, {16{8'hAA}}, {16{8'hFF}}, {16{8'h11}},
        {{11{8'h11}}, {5{8'h55}}});
    run("rsub32", 3'd2, 2'd2, 5'd4, {4{32'd5}}, {4{32'd3}}, 128'h0, {4{32'hFFFFFFFE}});
    run("minu32", 3'd6, 2'd2, 5'd4, {4{32'd5}}, {4{32'd3}}, 128'h0, {4{32'd3}});
    run("sub16_tail", 3'd1, 2'd1, 5'd3, {8{16'h0001}}, {8{16'h0002}}, {8{16'h2222}},
        {{5{16'h2222}}, {3{16'hFFFF}}});
    run("add16_nocarry", 3'd0, 2'd1, 5'd8, {8{16'hFFFF}}, {8{16'h0001}}, {8{16'h7777}}, 128'h0);
    run("maxu8_sat", 3'd7, 2'd0, 5'd31, 128'hFFEEDDCCBBAA99887766554433221100, {16{8'h80}},
        128'h0, 128'hFFEEDDCCBBAA99888080808080808080);
    run("or32_tail", 3'd4, 2'd2, 5'd2, {4{32'hF0F00000}}, {4{32'h00000F0F}},
        {4{32'hDEADBEEF}}, {{2{32'hDEADBEEF}}, {2{32'hF0F00F0F}}});
    run("and8", 3'd3, 2'd0, 5'd16, {8{16'hF00F}}, {16{8'h3C}}, 128'h0, {8{16'h300C}});
    run("add32_sat", 3'd0, 2'd2, 5'd31, {4{32'd1}}, {4{32'd2}}, 128'h0, {4{32'd3}});
    run("sew_rsv", 3'd0, 2'd3, 5'd16, {16{8'h01}}, {16{8'h02}}, {16{8'h5A}}, {16{8'h5A}});
    run("vl_zero", 3'd0, 2'd0, 5'd0, {16{8'h01}}, {16{8'h02}}, {16{8'hC3}}, {16{8'hC3}});

    // Backpressure; operands and in_valid are scrambled after accept and must be ignored.
    issue(3'd0, 2'd2, 5'd4, {4{32'd10}}, {4{32'd20}}, 128'h0);
    d1 = {4{32'h12345678}}; d2 = {4{32'h9ABCDEF0}}; op = 3'd5; vl = 5'd1; in_valid = 1'b1;
    chk("bp_busy", {busy, in_ready}, 2'b10);
    wait_out("bp");
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {out_valid, in_ready}, 2'b10);
      chk("bp_result", result, {4{32'd30}});
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready, busy}, 3'b010);

    // Reset while beat 2 is pending.
    issue(3'd0, 2'd0, 5'd16, {16{8'h11}}, {16{8'h22}}, 128'h0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("mid_rst_result", result, 128'h0);
    repeat (6) @(posedge clk);
    #1 chk("mid_rst_noval", out_valid, 1'b0);
    run("post_rst_add", 3'd0, 2'd0, 5'd16, {16{8'h11}}, {16{8'h22}}, 128'h0, {16{8'h33}});

    // out_ready held high: a single out_valid cycle, then back-to-back accept.
    out_ready = 1'b1;
    issue(3'd5, 2'd0, 5'd16, {16{8'h0F}}, {16{8'hF0}}, 128'h0);
    wait_out("rdy_hi");
    chk("rdy_hi_res", result, {16{8'hFF}});
    @(posedge clk); #1;
    chk("rdy_hi_one", {out_valid, in_ready}, 2'b01);
    issue(3'd0, 2'd2, 5'd4, {4{32'd7}}, {4{32'd8}}, 128'h0);
    wait_out("rdy_hi2");
    chk("rdy_hi2_res", result, {4{32'd15}});
    @(posedge clk); #1;
    chk("rdy_hi2_one", out_valid, 1'b0);
    out_ready = 1'b0;

    // Parameter sweep at VLEN=256.
    for (int t = 0; t < 8; t++) begin
      op_s  = 3'($urandom_range(0, 7));
      sew_s = 2'($urandom_range(0, 3));
      vl_s  = 6'($urandom_range(0, 40));
      for (int k = 0; k < 8; k++) begin
        d1s[32*k +: 32] = $urandom();
        d2s[32*k +: 32] = $urandom();
        d3s[32*k +: 32] = $urandom();
      end
      exp_s = model(op_s, sew_s, vl_s, d1s, d2s, d3s);
      in_valid_s = 1'b1;
      @(posedge clk); #1 in_valid_s = 1'b0;
      lat = '{0, 0, 0};
      n = 0;
      while (n < 20 && ov_s != 3'b111) begin
        @(posedge clk); #1;
        n++;
        for (int g = 0; g < 3; g++) if (ov_s[g] && lat[g] == 0) lat[g] = n;
      end
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("sw%0d_lat", g), lat[g], 8 >> g);
        chk($sformatf("sw%0d_res", g), res_s[g], exp_s);
      end
      out_ready_s = 1'b1;
      @(posedge clk); #1 out_ready_s = 1'b0;
      chk("sw_idle", {ov_s, ir_s}, 6'b000111);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_lane_exec_unit.md
VEC_LANE_EXEC_UNIT -- requirements
Module: vec_lane_exec_unit

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register width in bits; multiple of LANE_W.
REQ-002 SHALL have parameter LANE_W, default 32: datapath width processed per beat; multiple of 32.
REQ-003 SHALL derive localparam NBEATS = VLEN/LANE_W and VLW = $clog2(VLEN/8)+1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  instruction and operands valid.
REQ-008 in_ready  output  1  unit can accept an instruction.
REQ-009 op  input  3  000 add, 001 sub (d1-d2), 010 rsub (d2-d1), 011 and, 100 or, 101 xor, 110 minu, 111 maxu.
REQ-010 sew  input  2  00 8-bit, 01 16-bit, 10 32-bit, 11 reserved.
REQ-011 vl  input  VLW  active element count.
REQ-012 data_1, data_2  input  VLEN  source operands.
REQ-013 data_3  input  VLEN  old destination value, used for tail elements.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 result  output  VLEN  computed vector.
REQ-017 busy  output  1  high in EXEC or DONE.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-019 In IDLE: in_ready=1. On in_valid=1, SHALL latch op, sew, vl, data_1, data_2 and data_3, clear the beat counter and go to EXEC.
REQ-020 In EXEC: SHALL process beat k (bits k*LANE_W+:LANE_W) once per cycle, k = 0..NBEATS-1, and write that slice of the result register.
REQ-021 After beat NBEATS-1, SHALL go to DONE.
REQ-022 In DONE: out_valid=1 and result stable. On out_ready=1, SHALL go to IDLE.
REQ-023 in_ready SHALL be 0 in EXEC and DONE; in_valid is ignored there. No instruction overlap.
REQ-024 Latency: out_valid SHALL rise exactly NBEATS cycles after the accept edge, and is held until out_ready.
REQ-025 Element i SHALL be active iff i < vl; vl > VLEN/SEW saturates to VLEN/SEW.
REQ-026 Inactive (tail) elements SHALL take data_3's value (tail-undisturbed).
REQ-027 Arithmetic SHALL wrap modulo 2^SEW per element, with no carry across element boundaries.
REQ-028 minu and maxu SHALL compare elements as unsigned.
REQ-029 Lane logic SHALL be shared across all beats; only one LANE_W slice is computed per cycle.
REQ-030 sew=11: SHALL treat every element as tail, so result = data_3, with normal latency and handshake.
REQ-031 vl=0: result = data_3, with normal latency and handshake.
REQ-032 Operands SHALL be sampled only at accept; input changes during EXEC or DONE SHALL NOT affect the result.
REQ-033 If out_ready is held at 1 in DONE: one cycle of out_valid, then IDLE; the next accept is possible the cycle after.

Reset
REQ-034 On reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-EXEC and DONE.
REQ-035 After reset: in_ready=1, out_valid=0, busy=0, result=0, beat counter=0.
REQ-036 An instruction interrupted by reset SHALL produce no out_valid; its partial result SHALL be discarded.

Verification
REQ-037 Add with wrap: sew=00, vl=16, op=add, data_1 all bytes 0xFF, data_2 all bytes 0x01 -> result all 0x00; out_valid 4 cycles after accept.
REQ-038 Tail handling: sew=00, vl=5, op=xor, data_1=all 0xAA, data_2=all 0xFF, data_3=all 0x11 -> bytes 0..4 = 0x55, bytes 5..15 = 0x11.
REQ-039 rsub and minu at sew=10: data_1 words=5, data_2 words=3, vl=4.
  - op=rsub -> each word 0xFFFFFFFE.
  - op=minu -> each word 3.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1, result stable, in_ready=0 throughout; out_ready=1 -> IDLE the next cycle.
REQ-041 Reset mid-operation: assert reset at beat 2 of EXEC -> the next cycle is IDLE with out_valid=0 and result=0; a following add instruction completes correctly.
REQ-042 Parameter sweep: VLEN=256 with LANE_W=32, 64 and 128 -> latency 8, 4 and 2 cycles, results identical to a reference model for random op, sew and vl.
